// File: rtl/gfx_span_address_gen_pkg.sv
// Shared types and per-colour-depth constants for the span address generator.
//   color_depth_t : 3-bit pixel format code (BPP4..BPP32)
//   span_state_t  : controller state, exported for debug/checkers
//   f_bpp/f_cbpp  : bits per pixel / meaningful colour bits per pixel
//   f_pps         : whole pixels that fit in one strip of sw bits
//   f_recip       : floor(2^k / pps), used for the reciprocal divide
package gfx_span_address_gen_pkg;

  typedef enum logic [2:0] {
    BPP4  = 3'd0,
    BPP8  = 3'd1,
    BPP12 = 3'd2,
    BPP16 = 3'd3,
    BPP24 = 3'd4,
    BPP32 = 3'd5
  } color_depth_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP1 = 2'd1,
    SETUP2 = 2'd2,
    EMIT   = 2'd3
  } span_state_t;

  // Reserved codes 6 and 7 behave like BPP4.
  function automatic int f_bpp(color_depth_t d);
    case (d)
      BPP8:    return 8;
      BPP12:   return 12;
      BPP16:   return 16;
      BPP24:   return 24;
      BPP32:   return 32;
      default: return 4;
    endcase
  endfunction

  // BPP32 pixels carry two padding bits above 30 colour bits.
  function automatic int f_cbpp(color_depth_t d);
    return (d == BPP32) ? 30 : f_bpp(d);
  endfunction

  function automatic int f_pps(int sw, color_depth_t d);
    case (d)
      BPP8:    return sw / 8;
      BPP12:   return sw / 12;
      BPP16:   return sw / 16;
      BPP24:   return sw / 24;
      BPP32:   return sw / 32;
      default: return sw / 4;
    endcase
  endfunction

  // One constant per depth; each branch folds to a literal for fixed sw/k.
  function automatic logic [63:0] f_recip(int sw, color_depth_t d, int k);
    logic [63:0] one_k;
    one_k = 64'd1 << k;
    case (d)
      BPP8:    return one_k / 64'(sw / 8);
      BPP12:   return one_k / 64'(sw / 12);
      BPP16:   return one_k / 64'(sw / 16);
      BPP24:   return one_k / 64'(sw / 24);
      BPP32:   return one_k / 64'(sw / 32);
      default: return one_k / 64'(sw / 4);
    endcase
  endfunction

endpackage

// File: rtl/gfx_strip_divmod.sv
// Two-stage exact divide of x by pixels-per-strip.
//   clk, rst_n : clock, async active-low reset
//   depth_i    : colour depth selecting the divisor
//   x_i        : dividend (XW bits)
//   q_o, r_o   : floor(x/pps) and x mod pps, two cycles after x_i
// Stage 1 registers q_est = (x * floor(2^XW/pps)) >> XW, which is either
// the true quotient or one short (x < 2^XW bounds the error below 1).
// Stage 2 fixes that up by checking the remainder against pps.
module gfx_strip_divmod
  import gfx_span_address_gen_pkg::*;
#(
  parameter int SW = 256,
  parameter int XW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  color_depth_t depth_i,
  input  logic [XW-1:0] x_i,
  output logic [XW-1:0] q_o,
  output logic [XW-1:0] r_o
);

  localparam int RW = XW + 1;

  logic [RW-1:0] recip;
  logic [XW-1:0] pps;
  logic [XW-1:0] x_q, pps_q, qe_q;
  logic [XW-1:0] qp, re;

  always_comb begin
    recip = RW'(f_recip(SW, depth_i, XW));
    pps   = XW'(f_pps(SW, depth_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      pps_q <= '0;
      qe_q  <= '0;
    end else begin
      x_q   <= x_i;
      pps_q <= pps;
      qe_q  <= XW'(({{RW{1'b0}}, x_i} * {{XW{1'b0}}, recip}) >> XW);
    end
  end

  // qe_q never exceeds the true quotient, so qp cannot overflow x_q.
  always_comb begin
    qp = qe_q * pps_q;
    re = x_q - qp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
      r_o <= '0;
    end else if (re >= pps_q) begin
      q_o <= qe_q + XW'(1);
      r_o <= re - pps_q;
    end else begin
      q_o <= qe_q;
      r_o <= re;
    end
  end

endmodule

// File: rtl/gfx_span_address_gen.sv
// Horizontal span to strip-beat address generator.
//   clk, rst_n          : clock, async active-low reset
//   req_*               : span request (base, depth, bitmap width, x0, x1, y)
//   out_valid_o/ready_i : one beat per strip touched by the span
//   address_o           : strip byte address
//   mb_o/me_o/ce_o      : mask begin / mask end / colour-bits end positions
//   first_o/last_o      : beat position within the span
//   done_o              : one-cycle pulse when a span finishes (empty too)
//   state_o             : controller state for debug/checkers
// Handshake: both ports use valid/ready; a transfer happens on a rising
// clk edge where valid and ready are both high. The beat port holds every
// output stable while valid is high and ready is low, and valid never drops
// before its transfer. req_ready_o is only high in IDLE.
module gfx_span_address_gen
  import gfx_span_address_gen_pkg::*;
#(
  parameter  int SW = 256,
  parameter  int AW = 32,
  parameter  int CW = 16,
  localparam int BN = $clog2(SW) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] base_address_i,
  input  logic [2:0]    color_depth_i,
  input  logic [CW-1:0] bmp_width_i,
  input  logic [CW-1:0] x0_i,
  input  logic [CW-1:0] x1_i,
  input  logic [CW-1:0] y_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] address_o,
  output logic [BN:0]   mb_o,
  output logic [BN:0]   me_o,
  output logic [BN:0]   ce_o,
  output logic          first_o,
  output logic          last_o,
  output logic          done_o,
  output span_state_t   state_o
);

  localparam int MW = BN + 2;        // bit-position maths; holds a full bpp
  localparam int SB = $clog2(SW / 8);
  localparam int PW = CW + 1;        // ceil-divide numerator can reach 2^CW

  span_state_t  state_q, state_d;
  logic [AW-1:0] base_q;
  color_depth_t  depth_q;
  logic [CW-1:0] w_q, x0_q, x1_q, y_q;
  logic          accept, xfer;

  logic [CW-1:0] xs, xe_raw, xe;
  logic          empty;
  logic [PW-1:0] pitch_num, pitch_pps, pitch_est, pitch_rem, pitch;
  logic [PW:0]   pitch_recip;
  logic [PW-1:0] pitch_q;
  logic          empty_q;
  logic [AW-1:0] line_q;

  logic [CW-1:0] qs, rs, qe, re;
  logic [CW-1:0] off_q, cur;
  logic          first_b, last_b, done_q;
  logic [MW-1:0] bpp_m, pps_m, cdiff_m, mb_m, me_m, ce_m;

  assign accept = req_valid_i && req_ready_o;
  assign xfer   = (state_q == EMIT) && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      depth_q <= BPP4;
      w_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y_q     <= '0;
    end else if (accept) begin
      base_q  <= base_address_i;
      depth_q <= color_depth_t'(color_depth_i);
      w_q     <= bmp_width_i;
      x0_q    <= x0_i;
      x1_q    <= x1_i;
      y_q     <= y_i;
    end
  end

  // Normalise the span; with bmp_width 0 the wrapped clip is irrelevant
  // because the span is already empty.
  always_comb begin
    xs     = (x1_q < x0_q) ? x1_q : x0_q;
    xe_raw = (x1_q < x0_q) ? x0_q : x1_q;
    empty  = (xs >= w_q);
    xe     = (xe_raw >= w_q) ? (w_q - CW'(1)) : xe_raw;
  end

  // pitch = ceil(w/pps) = floor((w+pps-1)/pps), same reciprocal-and-fix
  // scheme as gfx_strip_divmod but collapsed into the first setup cycle.
  always_comb begin
    pitch_pps   = PW'(f_pps(SW, depth_q));
    pitch_recip = (PW+1)'(f_recip(SW, depth_q, PW));
    pitch_num   = {1'b0, w_q} + pitch_pps - PW'(1);
    pitch_est   = PW'(({{(PW+1){1'b0}}, pitch_num} * {{PW{1'b0}}, pitch_recip}) >> PW);
    pitch_rem   = pitch_num - pitch_est * pitch_pps;
    pitch       = (pitch_rem >= pitch_pps) ? (pitch_est + PW'(1)) : pitch_est;
  end

  // Captured inputs are frozen until the next accept, so these free-running
  // stages hold valid results for the whole span.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pitch_q <= '0;
      empty_q <= 1'b0;
      line_q  <= '0;
    end else begin
      pitch_q <= pitch;
      empty_q <= empty;
      line_q  <= AW'(y_q) * AW'(pitch_q);
    end
  end

  gfx_strip_divmod #(.SW(SW), .XW(CW)) u_div_xs (
    .clk(clk), .rst_n(rst_n), .depth_i(depth_q), .x_i(xs), .q_o(qs), .r_o(rs)
  );

  gfx_strip_divmod #(.SW(SW), .XW(CW)) u_div_xe (
    .clk(clk), .rst_n(rst_n), .depth_i(depth_q), .x_i(xe), .q_o(qe), .r_o(re)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP1;
      SETUP1:  state_d = SETUP2;
      SETUP2:  state_d = empty_q ? IDLE : EMIT;
      EMIT:    if (xfer && last_b) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat offset from the first strip, and the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (state_q == SETUP2) off_q <= '0;
      else if (xfer)         off_q <= off_q + CW'(1);
      done_q <= ((state_q == SETUP2) && empty_q) || (xfer && last_b);
    end
  end

  always_comb begin
    cur     = qs + off_q;
    first_b = (off_q == '0);
    last_b  = (cur == qe);
    bpp_m   = MW'(f_bpp(depth_q));
    pps_m   = MW'(f_pps(SW, depth_q));
    cdiff_m = MW'(f_bpp(depth_q) - f_cbpp(depth_q));
    mb_m    = first_b ? (MW'(rs) * bpp_m) : '0;
    me_m    = last_b ? (MW'(re) * bpp_m + bpp_m - MW'(1)) : (pps_m * bpp_m - MW'(1));
    ce_m    = me_m - cdiff_m;
  end

  // Output logic; everything but done_o is gated by state.
  always_comb begin
    req_ready_o = rst_n && (state_q == IDLE);
    out_valid_o = 1'b0;
    address_o   = '0;
    mb_o        = '0;
    me_o        = '0;
    ce_o        = '0;
    first_o     = 1'b0;
    last_o      = 1'b0;
    done_o      = done_q;
    state_o     = state_q;
    if (state_q == EMIT) begin
      out_valid_o = 1'b1;
      address_o   = base_q + ((line_q + AW'(cur)) << SB);
      mb_o        = (BN+1)'(mb_m);
      me_o        = (BN+1)'(me_m);
      ce_o        = (BN+1)'(ce_m);
      first_o     = first_b;
      last_o      = last_b;
    end
  end

endmodule

// File: tb/tb_gfx_span_address_gen.sv
module tb_gfx_span_address_gen;
  import gfx_span_address_gen_pkg::*;

  localparam int SW = 256;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int BN = $clog2(SW) - 1;
  localparam int W  = AW + 3 * (BN + 1) + 2;

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] base_address_i;
  logic [2:0]    color_depth_i;
  logic [CW-1:0] bmp_width_i, x0_i, x1_i, y_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [AW-1:0] address_o;
  logic [BN:0]   mb_o, me_o, ce_o;
  logic          first_o, last_o, done_o;
  span_state_t   state_o;

  gfx_span_address_gen #(.SW(SW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .base_address_i(base_address_i), .color_depth_i(color_depth_i),
    .bmp_width_i(bmp_width_i), .x0_i(x0_i), .x1_i(x1_i), .y_i(y_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .address_o(address_o), .mb_o(mb_o), .me_o(me_o), .ce_o(ce_o),
    .first_o(first_o), .last_o(last_o), .done_o(done_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] beat_now;
  int  beats_seen = 0;
  int  last_xfer_cyc = -100;
  int  first_cyc = -100;
  bit  rand_ready = 0;
  logic held_v = 1'b0;
  logic [W-1:0] held_b = '0;
  logic prev_ov = 1'b0;

  assign beat_now = {address_o, mb_o, me_o, ce_o, first_o, last_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input int mb, input int me, input int ce,
                           input bit f, input bit l);
    exp_q.push_back({a, (BN+1)'(mb), (BN+1)'(me), (BN+1)'(ce), f, l});
  endtask

  // Beat monitor: compares every transfer against the queue and checks that
  // a stalled beat does not change or disappear.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v  = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_beat", beat_now, held_b);
      end
      if (out_valid_o && !prev_ov) first_cyc = cyc;
      if (out_valid_o && out_ready_i) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat", beat_now, exp_q.pop_front());
        beats_seen++;
        if (last_o) last_xfer_cyc = cyc;
      end
      held_v  = out_valid_o && !out_ready_i;
      held_b  = beat_now;
      prev_ov = out_valid_o;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [AW-1:0] b, input logic [2:0] d, input int w,
                      input int x0, input int x1, input int y, output int acc);
    @(posedge clk);
    #1;
    req_valid_i    = 1'b1;
    base_address_i = b;
    color_depth_i  = d;
    bmp_width_i    = CW'(w);
    x0_i           = CW'(x0);
    x1_i           = CW'(x1);
    y_i            = CW'(y);
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid_i    = 1'b0;
    base_address_i = $urandom;
    color_depth_i  = 3'($urandom_range(0, 5));
    bmp_width_i    = CW'($urandom);
    x0_i           = CW'($urandom);
    x1_i           = CW'($urandom);
    y_i            = CW'($urandom);
    check("req_accepted", acc >= 0, 1);
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) begin
        dcyc = cyc;
        break;
      end
    end
    check(tag, dcyc >= 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  int acc, dcyc, n0;

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    base_address_i = '0;
    color_depth_i = '0;
    bmp_width_i = '0;
    x0_i = '0;
    x1_i = '0;
    y_i = '0;

    // Reset state
    #1;
    check("rst_req_ready", req_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_address", address_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready_o, 1);
    check("post_rst_state", state_o, IDLE);

    // 1: single pixel, BPP16
    push_beat(32'h1A00, 160, 175, 175, 1, 1);
    send(32'h1000, BPP16, 640, 10, 10, 2, acc);
    wait_done("t1_done_seen", dcyc);
    check("t1_first_latency", first_cyc - acc, 3);
    check("t1_done_latency", dcyc - last_xfer_cyc, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("t1_done_pulse_width", done_o, 0);

    // 2: swapped endpoints, three strips
    push_beat(32'h1A00, 224, 255, 255, 1, 0);
    push_beat(32'h1A20, 0, 255, 255, 0, 0);
    push_beat(32'h1A40, 0, 31, 31, 0, 1);
    send(32'h1000, BPP16, 640, 33, 14, 2, acc);
    wait_done("t2_done_seen", dcyc);
    check("t2_done_latency", dcyc - last_xfer_cyc, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: BPP24 (pitch 10) and BPP32 (colour bits end below mask end)
    push_beat(32'h2040, 120, 143, 143, 1, 1);
    send(32'h2000, BPP24, 100, 25, 25, 0, acc);
    wait_done("t3a_done_seen", dcyc);
    check("t3a_queue_empty", exp_q.size(), 0);
    push_beat(32'h2020, 32, 63, 61, 1, 1);
    send(32'h2000, BPP32, 100, 9, 9, 0, acc);
    wait_done("t3b_done_seen", dcyc);
    check("t3b_queue_empty", exp_q.size(), 0);
    // BPP32 pitch 13, y=1: line starts at strip 13
    push_beat(32'h2000 + 14 * 32, 32, 63, 61, 1, 1);
    send(32'h2000, BPP32, 100, 9, 9, 1, acc);
    wait_done("t3c_done_seen", dcyc);
    check("t3c_queue_empty", exp_q.size(), 0);

    // 4: clip at right edge, then a fully clipped (empty) span
    push_beat(32'h1EE0, 96, 255, 255, 1, 1);
    send(32'h1000, BPP16, 640, 630, 700, 2, acc);
    wait_done("t4a_done_seen", dcyc);
    check("t4a_queue_empty", exp_q.size(), 0);
    n0 = beats_seen;
    send(32'h1000, BPP16, 640, 700, 710, 2, acc);
    wait_done("t4b_done_seen", dcyc);
    check("t4b_done_latency", dcyc - acc, 3);
    check("t4b_no_beats", beats_seen - n0, 0);
    check("t4b_ready_at_done", req_ready_o, 1);

    // 5: five strips under random back-pressure
    push_beat(32'h1500, 80, 255, 255, 1, 0);
    push_beat(32'h1520, 0, 255, 255, 0, 0);
    push_beat(32'h1540, 0, 255, 255, 0, 0);
    push_beat(32'h1560, 0, 255, 255, 0, 0);
    push_beat(32'h1580, 0, 111, 111, 0, 1);
    rand_ready = 1;
    send(32'h1000, BPP16, 640, 70, 5, 1, acc);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) begin
        dcyc = cyc;
        break;
      end
      check("t5_busy_not_ready", req_ready_o, 0);
    end
    check("t5_done_seen", dcyc >= 0, 1);
    check("t5_done_latency", dcyc - last_xfer_cyc, 1);
    check("t5_queue_empty", exp_q.size(), 0);
    rand_ready = 0;
    out_ready_i = 1'b1;

    // 6: reset in the middle of EMIT
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    send(32'h1000, BPP16, 640, 5, 70, 1, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_o) break;
    end
    check("t6_in_emit", state_o, EMIT);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid_o, 0);
    check("t6_rst_address", address_o, 0);
    check("t6_rst_masks", {mb_o, me_o, ce_o}, 0);
    check("t6_rst_first_last", {first_o, last_o}, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_ready", req_ready_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_done", done_o, 0);
    end
    push_beat(32'h1A00, 224, 255, 255, 1, 0);
    push_beat(32'h1A20, 0, 255, 255, 0, 0);
    push_beat(32'h1A40, 0, 31, 31, 0, 1);
    send(32'h1000, BPP16, 640, 14, 33, 2, acc);
    wait_done("t6_done_seen", dcyc);
    check("t6_first_latency", first_cyc - acc, 3);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
